// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, counter width and receiver FSM state encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 12;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE      = 3'd0;
    localparam uart_state_t ST_START     = 3'd1;
    localparam uart_state_t ST_DATA      = 3'd2;
    localparam uart_state_t ST_STOP      = 3'd3;
    localparam uart_state_t ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Realigns its bit-period counter on every start edge
// so each data bit is sampled mid-bit; emits one-cycle data_valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1250,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ena,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_data_valid,
    output logic                 o_frame_err,
    output logic                 o_busy,
    output logic [2:0]           o_state
);

    localparam logic [CNT_W-1:0] LP_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LP_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LP_IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 w_bit_end;
    logic                 w_half_end;

    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    assign w_bit_end  = (r_cnt == LP_BIT_LAST);
    assign w_half_end = (r_cnt == LP_HALF_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else if (!i_ena) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    // A start bit must still be low at its midpoint, otherwise it was a glitch.
                    if (w_half_end) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= '0;
                        if (r_idx == LP_IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_STOP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start edge be caught from IDLE.
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_state      = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: serial frames are generated from the 8N1 rules and
// the expected strobe (kind, byte, start-edge time) is queued; a monitor pops on every strobe.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB    = 16;
    localparam int PERIOD = 10;
    localparam int HALF_P = PERIOD / 2;
    // Strobe nominally 9.5 bit periods after the start edge, +/-3 clk.
    localparam int NOM_NS = (CPB * 19 / 2) * PERIOD;
    localparam int TOL_NS = 3 * PERIOD;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [2:0] state;

    int total;
    int bad;
    logic [8:0] exp_q[$];
    longint     t_q[$];
    logic [7:0] last_good;
    longint     valid_t[$];
    logic       prev_ena;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ena        (ena),
        .i_rx         (rx),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_frame_err  (frame_err),
        .o_busy       (busy),
        .o_state      (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #HALF_P clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: a good frame presents its byte, a bad stop presents the previous good byte
    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
        t_q.push_back(longint'($time));
        last_good = b;
    endtask

    task automatic expect_ferr();
        exp_q.push_back({1'b1, last_good});
        t_q.push_back(longint'($time));
    endtask

    // driver: start bit, 8 data bits LSB first, stop bit; optional reset pulse inside bit abort_bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == abort_bit) begin
                repeat (CPB / 2) @(negedge clk);
                rst = 1'b1;
                rx  = 1'b1;
                @(negedge clk);
                chk("rst_mid data_out", 32'(data_out), 32'h00);
                chk("rst_mid data_valid", 32'(data_valid), 32'h0);
                chk("rst_mid frame_err", 32'(frame_err), 32'h0);
                chk("rst_mid busy", 32'(busy), 32'h0);
                rst = 1'b0;
                last_good = 8'h00;
                return;
            end
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && frame_err) begin
                bad++;
                $display("FAIL both_strobes: valid=%0b ferr=%0b at %0t", data_valid, frame_err, $time);
            end
            if (data_valid || frame_err) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=%0h, none expected at %0t",
                             data_valid, frame_err, data_out, $time);
                end else begin
                    logic [8:0] e;
                    longint     ft;
                    longint     dt;
                    e  = exp_q.pop_front();
                    ft = t_q.pop_front();
                    dt = longint'($time) - HALF_P - ft;
                    total++;
                    if ({frame_err, data_out} !== e) begin
                        bad++;
                        $display("FAIL strobe_value: got ferr=%0b data=%0h expected ferr=%0b data=%0h at %0t",
                                 frame_err, data_out, e[8], e[7:0], $time);
                    end
                    if (dt < NOM_NS - TOL_NS || dt > NOM_NS + TOL_NS) begin
                        bad++;
                        $display("FAIL strobe_timing: got %0d ns after start edge expected %0d+/-%0d",
                                 dt, NOM_NS, TOL_NS);
                    end
                    if (data_valid) valid_t.push_back(longint'($time));
                end
            end
            if (!prev_ena) begin
                total++;
                if (busy) begin
                    bad++;
                    $display("FAIL ena_low_busy: got busy=1 expected 0 at %0t", $time);
                end
            end
        end
        prev_ena = ena;
    end

    initial begin
        longint d;
        total = 0;
        bad = 0;
        last_good = 8'h00;
        prev_ena = 1'b1;
        rst = 1'b1;
        ena = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset data_out", 32'(data_out), 32'h00);
        chk("reset data_valid", 32'(data_valid), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset state", 32'(state), 32'(ST_IDLE));
        rst = 1'b0;
        idle(5);

        // single byte
        expect_byte(8'h55);
        send_frame(8'h55, 1'b1, -1);
        idle(3);
        chk("single busy_after", 32'(busy), 32'h0);
        chk("single data_out", 32'(data_out), 32'h55);
        idle(10);

        // back-to-back
        valid_t.delete();
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        expect_byte(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        idle(10);
        chk("b2b strobe_count", 32'(valid_t.size()), 32'd2);
        if (valid_t.size() == 2) begin
            d = valid_t[1] - valid_t[0];
            total++;
            if (d < longint'((10 * CPB - 3) * PERIOD) || d > longint'((10 * CPB + 3) * PERIOD)) begin
                bad++;
                $display("FAIL b2b_spacing: got %0d ns expected %0d+/-%0d", d, 10 * CPB * PERIOD, TOL_NS);
            end
        end

        // glitch rejection
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(12);
        chk("glitch busy", 32'(busy), 32'h0);
        chk("glitch data_out", 32'(data_out), 32'(last_good));
        idle(10);

        // framing error, long low, then recovery
        expect_ferr();
        send_frame(8'h81, 1'b0, -1);
        repeat (20) @(negedge clk);
        chk("ferr hold state_mid", 32'(state), 32'(ST_WAIT_IDLE));
        repeat (20) @(negedge clk);
        chk("ferr hold state_end", 32'(state), 32'(ST_WAIT_IDLE));
        chk("ferr data_out_kept", 32'(data_out), 32'(last_good));
        idle(4);
        chk("ferr released busy", 32'(busy), 32'h0);
        idle(6);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1, -1);
        idle(10);

        // reset in bit 3 of 0xF0, then 0x0F
        send_frame(8'hF0, 1'b1, 4);
        idle(CPB * 10);
        expect_byte(8'h0F);
        send_frame(8'h0F, 1'b1, -1);
        idle(10);

        // enable low while a frame is on the line
        ena = 1'b0;
        idle(3);
        send_frame(8'h99, 1'b1, -1);
        idle(5);
        chk("ena_low data_out", 32'(data_out), 32'h0F);
        ena = 1'b1;
        idle(5);
        expect_byte(8'h99);
        send_frame(8'h99, 1'b1, -1);
        idle(10);

        // randomised frames with random gaps (gap 0 = back-to-back)
        for (int n = 0; n < 8; n++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            expect_byte(b);
            send_frame(b, 1'b1, -1);
            idle(int'($urandom_range(0, 20)));
        end

        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk);
        chk("pending_expectations", 32'(exp_q.size()), 32'd0);
        chk("final busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
